// File: rtl/lsu_mem_port_if.sv
// Bundle of pipeline request/response and data-memory signals for lsu_mem_port.
// slave = the load/store unit; master = pipeline plus memory on the other side.
interface lsu_mem_port_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [31:0]       req_addr_i;
    logic [31:0]       req_wdata_i;
    logic [2:0]        req_load_type_i;
    logic [1:0]        req_store_type_i;

    logic              resp_valid_o;
    logic              resp_ready_i;
    logic [31:0]       resp_rdata_o;
    logic              resp_fault_o;

    logic              mem_rd_en_o;
    logic              mem_wr_en_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wr_data_o;
    logic [2:0]        mem_load_type_o;
    logic [1:0]        mem_store_type_o;
    logic [31:0]       mem_rd_data_i;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
               req_load_type_i, req_store_type_i, resp_ready_i, mem_rd_data_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_fault_o,
               mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wr_data_o,
               mem_load_type_o, mem_store_type_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
               req_load_type_i, req_store_type_i, resp_ready_i, mem_rd_data_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_fault_o,
               mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wr_data_o,
               mem_load_type_o, mem_store_type_o
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store port: checks a MEM-stage request, issues one
// memory cycle, and holds the response until the pipeline takes it.
module lsu_mem_port #(
    parameter int ADDR_W    = 8,
    parameter bit CHK_ALIGN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    lsu_mem_port_if.slave       bus,
    output logic [1:0]          state_o
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; valid holds its payload until then, ready never waits on valid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        ltype_q, ltype_d;
    logic [1:0]        stype_q, stype_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              fault_q, fault_d;

    logic addr_hi_bad;
    logic type_bad;
    logic misalign;
    logic req_fault;

    assign addr_hi_bad = (bus.req_addr_i >> ADDR_W) != 32'd0;

    always_comb begin
        type_bad = 1'b0;
        misalign = 1'b0;
        if (bus.req_we_i) begin
            type_bad = (bus.req_store_type_i == 2'd3);
            misalign = ((bus.req_store_type_i == 2'd1) && bus.req_addr_i[0]) ||
                       ((bus.req_store_type_i == 2'd2) && (bus.req_addr_i[1:0] != 2'd0));
        end else begin
            type_bad = (bus.req_load_type_i == 3'd3) || (bus.req_load_type_i >= 3'd6);
            misalign = (((bus.req_load_type_i == 3'd1) || (bus.req_load_type_i == 3'd5)) &&
                        bus.req_addr_i[0]) ||
                       ((bus.req_load_type_i == 3'd2) && (bus.req_addr_i[1:0] != 2'd0));
        end
        req_fault = addr_hi_bad | type_bad | (CHK_ALIGN & misalign);
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ltype_d = ltype_q;
        stype_d = stype_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    we_d    = bus.req_we_i;
                    addr_d  = bus.req_addr_i[ADDR_W-1:0];
                    wdata_d = bus.req_wdata_i;
                    ltype_d = bus.req_load_type_i;
                    stype_d = bus.req_store_type_i;
                    rdata_d = 32'd0;
                    fault_d = req_fault;
                    // A faulting request skips memory entirely.
                    state_d = req_fault ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                rdata_d = we_q ? 32'd0 : bus.mem_rd_data_i;
                fault_d = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                if (bus.resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            ltype_q <= 3'd0;
            stype_q <= 2'd0;
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ltype_q <= ltype_d;
            stype_q <= stype_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Enables are gated by rst directly so a reset landing on ISSUE never writes.
    assign bus.mem_rd_en_o      = (state_q == ISSUE) && !we_q && !rst;
    assign bus.mem_wr_en_o      = (state_q == ISSUE) &&  we_q && !rst;
    assign bus.mem_addr_o       = addr_q;
    assign bus.mem_wr_data_o    = wdata_q;
    assign bus.mem_load_type_o  = ltype_q;
    assign bus.mem_store_type_o = stype_q;

    assign bus.req_ready_o  = (state_q == IDLE);
    assign bus.resp_valid_o = (state_q == RESP);
    assign bus.resp_rdata_o = rdata_q;
    assign bus.resp_fault_o = fault_q;
    assign state_o          = state_q;
endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: byte-array memory, transaction-level reference model
// with an expected-response queue, directed and randomized scenarios.
module tb_lsu_mem_port;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_mem_port_if #(.ADDR_W(ADDR_W)) bus ();
    lsu_mem_port_if #(.ADDR_W(ADDR_W)) bus_na ();
    logic [1:0] state;
    logic [1:0] state_na;

    lsu_mem_port #(.ADDR_W(ADDR_W), .CHK_ALIGN(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .state_o(state)
    );
    lsu_mem_port #(.ADDR_W(ADDR_W), .CHK_ALIGN(1'b0)) dut_na (
        .clk(clk), .rst(rst), .bus(bus_na.slave), .state_o(state_na)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  phys_mem [256];
    logic [7:0]  ref_mem  [256];
    logic [32:0] exp_q [$];
    int rd_pulses = 0, wr_pulses = 0, overlap = 0, na_rd_pulses = 0;

    // ---------------- memory environment ----------------
    function automatic logic [31:0] load_ext(input logic [7:0] b0, b1, b2, b3,
                                             input logic [2:0] t);
        case (t)
            3'd0: return {{24{b0[7]}}, b0};
            3'd1: return {{16{b1[7]}}, b1, b0};
            3'd2: return {b3, b2, b1, b0};
            3'd4: return {24'd0, b0};
            3'd5: return {16'd0, b1, b0};
            default: return 32'd0;
        endcase
    endfunction

    logic [7:0] ma;
    always_comb begin
        ma = bus.mem_addr_o;
        bus.mem_rd_data_i = load_ext(phys_mem[ma], phys_mem[ma + 8'd1],
                                     phys_mem[ma + 8'd2], phys_mem[ma + 8'd3],
                                     bus.mem_load_type_o);
    end
    assign bus_na.mem_rd_data_i = 32'hCAFE_F00D;

    always @(posedge clk) begin
        if (bus.mem_rd_en_o) rd_pulses++;
        if (bus.mem_wr_en_o) wr_pulses++;
        if (bus.mem_rd_en_o && bus.mem_wr_en_o) overlap++;
        if (bus_na.mem_rd_en_o) na_rd_pulses++;
        if (bus.mem_wr_en_o) begin
            phys_mem[ma] <= bus.mem_wr_data_o[7:0];
            if (bus.mem_store_type_o != 2'd0) phys_mem[ma + 8'd1] <= bus.mem_wr_data_o[15:8];
            if (bus.mem_store_type_o == 2'd2) begin
                phys_mem[ma + 8'd2] <= bus.mem_wr_data_o[23:16];
                phys_mem[ma + 8'd3] <= bus.mem_wr_data_o[31:24];
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic predict(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] lt, input logic [1:0] st,
                           output logic fault, output logic [31:0] rdata);
        int size;
        bit type_ok, sgn;
        logic [31:0] val;
        if (we) begin
            type_ok = (st < 2'd3);
            size = (st == 2'd0) ? 1 : (st == 2'd1) ? 2 : 4;
            sgn = 1'b0;
        end else begin
            type_ok = (lt == 3'd0) || (lt == 3'd1) || (lt == 3'd2) || (lt == 3'd4) || (lt == 3'd5);
            size = (lt == 3'd2) ? 4 : ((lt == 3'd1) || (lt == 3'd5)) ? 2 : 1;
            sgn = (lt < 3'd3);
        end
        fault = (addr >= 32'd256) || !type_ok || ((addr % size) != 0);
        rdata = 32'd0;
        if (!fault) begin
            if (we) begin
                for (int i = 0; i < size; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                val = 32'd0;
                for (int i = 0; i < size; i++) val = val | (32'(ref_mem[int'(addr) + i]) << (8*i));
                if (sgn && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8*size)) - 32'd1);
                rdata = val;
            end
        end
    endtask

    // ---------------- driver / transaction ----------------
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] lt, input logic [1:0] st, input int hold);
        logic [32:0] exp, got;
        logic        exp_fault;
        logic [31:0] exp_rdata;
        int rd0, wr0, t, exp_rd, exp_wr;
        predict(we, addr, wdata, lt, st, exp_fault, exp_rdata);
        exp_q.push_back({exp_fault, exp_rdata});
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_we_i = we;
        bus.req_addr_i = addr;
        bus.req_wdata_i = wdata;
        bus.req_load_type_i = lt;
        bus.req_store_type_i = st;
        t = 0;
        while (bus.req_ready_o !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 20) begin
            $display("FAIL accept_timeout: req_ready_o=%b, required 1", bus.req_ready_o);
            errors++;
            bus.req_valid_i = 1'b0;
            void'(exp_q.pop_back());
            return;
        end
        rd0 = rd_pulses;
        wr0 = wr_pulses;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        exp = exp_q.pop_front();
        if (!exp_fault) begin
            checks++;
            if (bus.resp_valid_o !== 1'b0 || bus.mem_rd_en_o !== ~we || bus.mem_wr_en_o !== we)
                begin
                $display("FAIL issue_enables: valid=%b rd=%b wr=%b, required 0 %b %b",
                         bus.resp_valid_o, bus.mem_rd_en_o, bus.mem_wr_en_o, ~we, we);
                errors++;
            end
            checks++;
            if (bus.mem_addr_o !== addr[7:0]) begin
                $display("FAIL issue_addr: got %h, required %h", bus.mem_addr_o, addr[7:0]);
                errors++;
            end
            checks++;
            if (we && (bus.mem_wr_data_o !== wdata || bus.mem_store_type_o !== st)) begin
                $display("FAIL issue_store: data=%h type=%0d, required %h %0d",
                         bus.mem_wr_data_o, bus.mem_store_type_o, wdata, st);
                errors++;
            end else if (!we && bus.mem_load_type_o !== lt) begin
                $display("FAIL issue_load_type: got %0d, required %0d", bus.mem_load_type_o, lt);
                errors++;
            end
            @(negedge clk);
        end
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) @(negedge clk);
            got = {bus.resp_fault_o, bus.resp_rdata_o};
            checks++;
            if (bus.resp_valid_o !== 1'b1 || got !== exp || bus.req_ready_o !== 1'b0) begin
                $display("FAIL resp_hold%0d: valid=%b ready=%b fault/rdata=%h, required 1 0 %h",
                         i, bus.resp_valid_o, bus.req_ready_o, got, exp);
                errors++;
            end
        end
        bus.resp_ready_i = 1'b1;
        @(negedge clk);
        bus.resp_ready_i = 1'b0;
        checks++;
        if (bus.resp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
            $display("FAIL resp_consume: valid=%b ready=%b, required 0 1",
                     bus.resp_valid_o, bus.req_ready_o);
            errors++;
        end
        exp_rd = (!exp_fault && !we) ? 1 : 0;
        exp_wr = (!exp_fault && we) ? 1 : 0;
        checks++;
        if ((rd_pulses - rd0) != exp_rd || (wr_pulses - wr0) != exp_wr) begin
            $display("FAIL mem_pulses: rd=%0d wr=%0d, required %0d %0d",
                     rd_pulses - rd0, wr_pulses - wr0, exp_rd, exp_wr);
            errors++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.resp_valid_o !== 1'b0 || bus.resp_fault_o !== 1'b0 || bus.resp_rdata_o !== 32'd0) begin
            $display("FAIL reset_resp: valid=%b fault=%b rdata=%h, required 0 0 0",
                     bus.resp_valid_o, bus.resp_fault_o, bus.resp_rdata_o);
            errors++;
        end
        checks++;
        if (bus.mem_rd_en_o !== 1'b0 || bus.mem_wr_en_o !== 1'b0 || bus.mem_addr_o !== 8'd0 ||
            bus.mem_wr_data_o !== 32'd0 || bus.mem_load_type_o !== 3'd0 ||
            bus.mem_store_type_o !== 2'd0) begin
            $display("FAIL reset_mem: rd=%b wr=%b addr=%h data=%h lt=%0d st=%0d, required all 0",
                     bus.mem_rd_en_o, bus.mem_wr_en_o, bus.mem_addr_o, bus.mem_wr_data_o,
                     bus.mem_load_type_o, bus.mem_store_type_o);
            errors++;
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready_o !== 1'b1) begin
            $display("FAIL reset_ready: got %b, required 1", bus.req_ready_o);
            errors++;
        end
    endtask

    task automatic test_store_load();
        run_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 3'd0, 2'd2, 0);
        run_txn(1'b0, 32'h10, 32'd0, 3'd2, 2'd0, 0);
        checks++;
        if ({ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]} !== 32'hDEAD_BEEF) begin
            $display("FAIL model_sw_image: got %h, required deadbeef",
                     {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]});
            errors++;
        end
        run_txn(1'b1, 32'h42, 32'h0000_80F1, 3'd0, 2'd1, 0);
        run_txn(1'b0, 32'h42, 32'd0, 3'd1, 2'd0, 0);
        run_txn(1'b0, 32'h42, 32'd0, 3'd5, 2'd0, 0);
        run_txn(1'b0, 32'h42, 32'd0, 3'd0, 2'd0, 0);
    endtask

    task automatic test_faults();
        run_txn(1'b0, 32'h13, 32'd0, 3'd1, 2'd0, 0);
        run_txn(1'b0, 32'h12, 32'd0, 3'd2, 2'd0, 0);
        run_txn(1'b1, 32'h11, 32'h1234_5678, 3'd0, 2'd1, 0);
        run_txn(1'b0, 32'h0000_0100, 32'd0, 3'd4, 2'd0, 0);
        run_txn(1'b0, 32'h20, 32'd0, 3'd3, 2'd0, 0);
        run_txn(1'b0, 32'h20, 32'd0, 3'd6, 2'd0, 0);
        run_txn(1'b0, 32'h20, 32'd0, 3'd7, 2'd0, 0);
        run_txn(1'b1, 32'h40, 32'hA5A5_A5A5, 3'd0, 2'd3, 0);
        run_txn(1'b1, 32'h8000_0040, 32'hA5A5_A5A5, 3'd0, 2'd0, 0);
    endtask

    task automatic test_no_align();
        int rd0;
        rd0 = na_rd_pulses;
        @(negedge clk);
        bus_na.req_we_i = 1'b0;
        bus_na.req_addr_i = 32'h13;
        bus_na.req_load_type_i = 3'd1;
        bus_na.req_valid_i = 1'b1;
        checks++;
        if (bus_na.req_ready_o !== 1'b1) begin
            $display("FAIL na_ready: got %b, required 1", bus_na.req_ready_o);
            errors++;
        end
        @(negedge clk);
        bus_na.req_valid_i = 1'b0;
        checks++;
        if (bus_na.mem_rd_en_o !== 1'b1 || bus_na.mem_addr_o !== 8'h13) begin
            $display("FAIL na_issue: rd=%b addr=%h, required 1 13", bus_na.mem_rd_en_o,
                     bus_na.mem_addr_o);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (bus_na.resp_valid_o !== 1'b1 || bus_na.resp_fault_o !== 1'b0 ||
            bus_na.resp_rdata_o !== 32'hCAFE_F00D) begin
            $display("FAIL na_resp: valid=%b fault=%b rdata=%h, required 1 0 cafef00d",
                     bus_na.resp_valid_o, bus_na.resp_fault_o, bus_na.resp_rdata_o);
            errors++;
        end
        bus_na.resp_ready_i = 1'b1;
        @(negedge clk);
        bus_na.resp_ready_i = 1'b0;
        checks++;
        if (na_rd_pulses - rd0 != 1 || bus_na.req_ready_o !== 1'b1) begin
            $display("FAIL na_done: rd pulses=%0d ready=%b, required 1 1",
                     na_rd_pulses - rd0, bus_na.req_ready_o);
            errors++;
        end
    endtask

    task automatic test_backpressure();
        run_txn(1'b0, 32'h10, 32'd0, 3'd2, 2'd0, 5);
        run_txn(1'b0, 32'h13, 32'd0, 3'd1, 2'd0, 5);
    endtask

    task automatic test_reset_mid();
        logic [7:0] old;
        int wr0;
        old = ref_mem[32];
        wr0 = wr_pulses;
        @(negedge clk);
        bus.req_we_i = 1'b1;
        bus.req_addr_i = 32'h20;
        bus.req_wdata_i = {24'h0, ~old};
        bus.req_store_type_i = 2'd0;
        bus.req_load_type_i = 3'd0;
        bus.req_valid_i = 1'b1;
        checks++;
        if (bus.req_ready_o !== 1'b1) begin
            $display("FAIL rst_issue_ready: got %b, required 1", bus.req_ready_o);
            errors++;
        end
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.mem_wr_en_o !== 1'b0 || bus.mem_addr_o !== 8'h20) begin
            $display("FAIL rst_issue_wr: wr=%b addr=%h, required 0 20", bus.mem_wr_en_o,
                     bus.mem_addr_o);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (bus.resp_valid_o !== 1'b0 || bus.resp_fault_o !== 1'b0 || bus.resp_rdata_o !== 32'd0 ||
            bus.mem_addr_o !== 8'd0 || bus.mem_wr_data_o !== 32'd0 ||
            bus.mem_store_type_o !== 2'd0 || bus.mem_wr_en_o !== 1'b0) begin
            $display("FAIL rst_issue_outputs: valid=%b fault=%b rdata=%h addr=%h wdata=%h st=%0d, required all 0",
                     bus.resp_valid_o, bus.resp_fault_o, bus.resp_rdata_o, bus.mem_addr_o,
                     bus.mem_wr_data_o, bus.mem_store_type_o);
            errors++;
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready_o !== 1'b1 || wr_pulses != wr0) begin
            $display("FAIL rst_issue_after: ready=%b wr pulses=%0d, required 1 0",
                     bus.req_ready_o, wr_pulses - wr0);
            errors++;
        end
        run_txn(1'b0, 32'h20, 32'd0, 3'd4, 2'd0, 0);

        @(negedge clk);
        bus.req_we_i = 1'b0;
        bus.req_addr_i = 32'h10;
        bus.req_load_type_i = 3'd2;
        bus.req_valid_i = 1'b1;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.resp_valid_o !== 1'b1) begin
            $display("FAIL rst_resp_pre: valid=%b, required 1", bus.resp_valid_o);
            errors++;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.resp_valid_o !== 1'b0 || bus.resp_rdata_o !== 32'd0 || bus.mem_addr_o !== 8'd0 ||
            bus.mem_load_type_o !== 3'd0) begin
            $display("FAIL rst_resp_outputs: valid=%b rdata=%h addr=%h lt=%0d, required all 0",
                     bus.resp_valid_o, bus.resp_rdata_o, bus.mem_addr_o, bus.mem_load_type_o);
            errors++;
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic        w [3];
        logic [31:0] a [3];
        logic [31:0] d [3];
        logic [2:0]  l [3];
        logic [1:0]  s [3];
        logic [2:0]  lts [5];
        logic        f;
        logic [31:0] r;
        logic [32:0] exp, got;
        int acc [3];
        int idx, cyc, nresp;
        bit accepting;
        lts = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < 3; i++) begin
            w[i] = 1'($urandom_range(0, 1));
            a[i] = 32'($urandom_range(0, 63) * 4);
            d[i] = $urandom;
            l[i] = lts[$urandom_range(0, 4)];
            s[i] = 2'($urandom_range(0, 2));
            acc[i] = 0;
            predict(w[i], a[i], d[i], l[i], s[i], f, r);
            exp_q.push_back({f, r});
        end
        bus.resp_ready_i = 1'b1;
        @(negedge clk);
        idx = 0;
        cyc = 0;
        nresp = 0;
        bus.req_we_i = w[0];
        bus.req_addr_i = a[0];
        bus.req_wdata_i = d[0];
        bus.req_load_type_i = l[0];
        bus.req_store_type_i = s[0];
        bus.req_valid_i = 1'b1;
        while ((idx < 3 || nresp < 3) && cyc < 60) begin
            accepting = bus.req_valid_i && bus.req_ready_o;
            if (bus.resp_valid_o === 1'b1 && exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = {bus.resp_fault_o, bus.resp_rdata_o};
                checks++;
                if (got !== exp) begin
                    $display("FAIL b2b_resp%0d: fault/rdata=%h, required %h", nresp, got, exp);
                    errors++;
                end
                nresp++;
            end
            @(negedge clk);
            cyc++;
            if (accepting) begin
                acc[idx] = cyc;
                idx++;
                if (idx < 3) begin
                    bus.req_we_i = w[idx];
                    bus.req_addr_i = a[idx];
                    bus.req_wdata_i = d[idx];
                    bus.req_load_type_i = l[idx];
                    bus.req_store_type_i = s[idx];
                end else begin
                    bus.req_valid_i = 1'b0;
                end
            end
        end
        bus.req_valid_i = 1'b0;
        bus.resp_ready_i = 1'b0;
        checks++;
        if (idx != 3 || nresp != 3) begin
            $display("FAIL b2b_timeout: accepted=%0d responses=%0d, required 3 3", idx, nresp);
            errors++;
            exp_q.delete();
        end
        checks++;
        if (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3) begin
            $display("FAIL b2b_spacing: gaps %0d %0d, required 3 3", acc[1] - acc[0],
                     acc[2] - acc[1]);
            errors++;
        end
    endtask

    task automatic test_random();
        logic        we;
        logic [31:0] addr;
        logic [2:0]  lt;
        logic [1:0]  st;
        logic [2:0]  lts [5];
        logic [2:0]  bad [3];
        lts = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        bad = '{3'd3, 3'd6, 3'd7};
        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom_range(0, 1));
            lt = ($urandom_range(0, 7) == 0) ? bad[$urandom_range(0, 2)] : lts[$urandom_range(0, 4)];
            st = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            addr = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'h3;
            if ($urandom_range(0, 9) == 0) addr = addr + (32'h100 << $urandom_range(0, 23));
            run_txn(we, addr, $urandom, lt, st, $urandom_range(0, 3));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            phys_mem[i] = 8'($urandom);
            ref_mem[i] = phys_mem[i];
        end
        rst = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_we_i = 1'b0;
        bus.req_addr_i = 32'd0;
        bus.req_wdata_i = 32'd0;
        bus.req_load_type_i = 3'd0;
        bus.req_store_type_i = 2'd0;
        bus.resp_ready_i = 1'b0;
        bus_na.req_valid_i = 1'b0;
        bus_na.req_we_i = 1'b0;
        bus_na.req_addr_i = 32'd0;
        bus_na.req_wdata_i = 32'd0;
        bus_na.req_load_type_i = 3'd0;
        bus_na.req_store_type_i = 2'd0;
        bus_na.resp_ready_i = 1'b0;

        test_reset();
        test_store_load();
        test_faults();
        test_no_align();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();

        checks++;
        if (overlap != 0) begin
            $display("FAIL enable_overlap: %0d cycles with both enables, required 0", overlap);
            errors++;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
